// File: rtl/crpa_cmult_if.sv
// Sample/weight/control bundle for the CRPA complex multiplier.
// The master drives the sample side; the slave is the multiplier.
interface crpa_cmult_if #(
    parameter int A_width   = 16,
    parameter int B_width   = 16,
    parameter int OUT_width = 16
);
    logic                        ce;
    logic                        clr;
    logic                        in_valid;
    logic                        conj;
    logic signed [A_width-1:0]   A_re;
    logic signed [A_width-1:0]   A_im;
    logic signed [B_width-1:0]   B_re;
    logic signed [B_width-1:0]   B_im;
    logic                        out_valid;
    logic signed [OUT_width-1:0] M_re;
    logic signed [OUT_width-1:0] M_im;
    logic                        out_sat;
    logic [15:0]                 sat_cnt;

    modport master (
        output ce, clr, in_valid, conj, A_re, A_im, B_re, B_im,
        input  out_valid, M_re, M_im, out_sat, sat_cnt
    );

    modport slave (
        input  ce, clr, in_valid, conj, A_re, A_im, B_re, B_im,
        output out_valid, M_re, M_im, out_sat, sat_cnt
    );
endinterface

// File: rtl/crpa_cmult.sv
// Four-stage complex multiplier (optional conjugate weight) with round-half-up,
// per-component saturation and a sticky saturation counter.
module crpa_cmult #(
    parameter int A_width   = 16,
    parameter int B_width   = 16,
    parameter int OUT_width = 16,
    parameter int SHIFT     = 15
) (
    input  logic        clk,
    input  logic        resetn,
    crpa_cmult_if.slave bus
);
    localparam int PW = A_width + B_width;
    localparam int P  = PW + 1;
    localparam int R  = P + 1;

    // Rounding constant is zero when SHIFT is zero, so one datapath covers both cases.
    localparam logic signed [R-1:0] HALF = (R'(1) << SHIFT) >> 1;
    localparam logic signed [R-1:0] MAXV = (R'(1) << (OUT_width - 1)) - R'(1);
    localparam logic signed [R-1:0] MINV = -(R'(1) << (OUT_width - 1));

    logic signed [A_width-1:0] a_re, a_im;
    logic signed [B_width-1:0] b_re, b_im;
    logic                      conj1, v1;

    logic signed [PW-1:0]      p_rr, p_ii, p_ri, p_ir;
    logic                      conj2, v2;

    logic signed [P-1:0]       sum_re, sum_im;
    logic                      v3;

    logic signed [R-1:0]       rnd_re, rnd_im;
    logic [OUT_width:0]        cl_re, cl_im;

    function automatic logic [OUT_width:0] clamp(input logic signed [R-1:0] v);
        if (v > MAXV)
            return {1'b1, MAXV[OUT_width-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[OUT_width-1:0]};
        else
            return {1'b0, v[OUT_width-1:0]};
    endfunction

    // NOTE: every output of an always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        rnd_re = (R'(sum_re) + HALF) >>> SHIFT;
        rnd_im = (R'(sum_im) + HALF) >>> SHIFT;
        cl_re  = clamp(rnd_re);
        cl_im  = clamp(rnd_im);
    end

    // NOTE: state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_re          <= '0;
            a_im          <= '0;
            b_re          <= '0;
            b_im          <= '0;
            conj1         <= 1'b0;
            v1            <= 1'b0;
            p_rr          <= '0;
            p_ii          <= '0;
            p_ri          <= '0;
            p_ir          <= '0;
            conj2         <= 1'b0;
            v2            <= 1'b0;
            sum_re        <= '0;
            sum_im        <= '0;
            v3            <= 1'b0;
            bus.M_re      <= '0;
            bus.M_im      <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_valid <= 1'b0;
        end else if (bus.ce) begin
            a_re          <= bus.A_re;
            a_im          <= bus.A_im;
            b_re          <= bus.B_re;
            b_im          <= bus.B_im;
            conj1         <= bus.conj;
            v1            <= bus.in_valid;

            p_rr          <= PW'(a_re) * PW'(b_re);
            p_ii          <= PW'(a_im) * PW'(b_im);
            p_ri          <= PW'(a_re) * PW'(b_im);
            p_ir          <= PW'(a_im) * PW'(b_re);
            conj2         <= conj1;
            v2            <= v1;

            // Conjugating the weight flips the sign of every B_im term.
            sum_re        <= conj2 ? P'(p_rr) + P'(p_ii) : P'(p_rr) - P'(p_ii);
            sum_im        <= conj2 ? P'(p_ir) - P'(p_ri) : P'(p_ri) + P'(p_ir);
            v3            <= v2;

            bus.M_re      <= cl_re[OUT_width-1:0];
            bus.M_im      <= cl_im[OUT_width-1:0];
            bus.out_sat   <= cl_re[OUT_width] | cl_im[OUT_width];
            bus.out_valid <= v3;
        end
    end

    // Clear wins over counting and does not wait for ce.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus.sat_cnt <= '0;
        else if (bus.clr)
            bus.sat_cnt <= '0;
        else if (bus.ce && bus.out_valid && bus.out_sat && (bus.sat_cnt != 16'hFFFF))
            bus.sat_cnt <= bus.sat_cnt + 16'd1;
    end
endmodule

// File: tb/tb_crpa_cmult.sv
// Randomised and directed bench for crpa_cmult against an arithmetic reference
// model with a ce-cycle latency queue and a modelled saturation counter.
module tb_crpa_cmult;
    localparam int A_W   = 16;
    localparam int B_W   = 16;
    localparam int OUT_W = 16;
    localparam int SHIFT = 15;
    localparam int LAT   = 4;

    typedef struct {
        bit     v;
        longint re;
        longint im;
        bit     sat;
    } res_t;

    logic clk = 1'b0;
    logic resetn;

    crpa_cmult_if #(.A_width(A_W), .B_width(B_W), .OUT_width(OUT_W)) bus ();

    crpa_cmult #(
        .A_width(A_W), .B_width(B_W), .OUT_width(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_asserts = 0;
    int   n_fails   = 0;

    int   ar, ai, br, bi;
    bit   cj, iv, ce_v, clr_v;

    res_t hist[$];
    res_t cur;
    int   exp_cnt;

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Round-half-up as floor((x + d/2) / d) with d = 2^SHIFT.
    function automatic longint scale(input longint x);
        longint d, n, q;
        d = longint'(1) << SHIFT;
        n = x + d / 2;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    function automatic res_t ref_mult(input int a_r, a_i, b_r, b_i, input bit c, input bit v);
        res_t   r;
        longint re, im, lim;
        if (c) begin
            re = longint'(a_r) * b_r + longint'(a_i) * b_i;
            im = longint'(a_i) * b_r - longint'(a_r) * b_i;
        end else begin
            re = longint'(a_r) * b_r - longint'(a_i) * b_i;
            im = longint'(a_r) * b_i + longint'(a_i) * b_r;
        end
        re    = scale(re);
        im    = scale(im);
        lim   = longint'(1) << (OUT_W - 1);
        r.sat = (re >= lim) || (re < -lim) || (im >= lim) || (im < -lim);
        r.re  = (re >= lim) ? lim - 1 : (re < -lim) ? -lim : re;
        r.im  = (im >= lim) ? lim - 1 : (im < -lim) ? -lim : im;
        r.v   = v;
        return r;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r.v = 1'b0; r.re = 0; r.im = 0; r.sat = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < LAT - 1; i++) hist.push_back(zero_res());
        cur     = zero_res();
        exp_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        chk("out_valid", bus.out_valid, cur.v);
        chk("M_re",      bus.M_re,      cur.re);
        chk("M_im",      bus.M_im,      cur.im);
        chk("out_sat",   bus.out_sat,   cur.sat);
        chk("sat_cnt",   bus.sat_cnt,   exp_cnt);
    endtask

    task automatic lit(input string tag, input int re, input int im, input bit sat);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_re"},    bus.M_re,      re);
        chk({tag, "_im"},    bus.M_im,      im);
        chk({tag, "_sat"},   bus.out_sat,   sat);
    endtask

    // Drive the current stimulus, clock once, advance the model, compare.
    task automatic cycle();
        bus.ce       = ce_v;
        bus.clr      = clr_v;
        bus.in_valid = iv;
        bus.conj     = cj;
        bus.A_re     = A_W'(ar);
        bus.A_im     = A_W'(ai);
        bus.B_re     = B_W'(br);
        bus.B_im     = B_W'(bi);
        @(posedge clk);
        #1;
        if (clr_v)
            exp_cnt = 0;
        else if (ce_v && cur.v && cur.sat && exp_cnt != 16'hFFFF)
            exp_cnt++;
        if (ce_v) begin
            hist.push_back(ref_mult(ar, ai, br, bi, cj, iv));
            cur = hist.pop_front();
        end
        check_model();
    endtask

    task automatic send(input bit c, input int a_r, a_i, b_r, b_i);
        ce_v = 1'b1; iv = 1'b1; cj = c;
        ar = a_r; ai = a_i; br = b_r; bi = b_i;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ce_v = 1'b1; iv = 1'b0; cj = 1'($urandom_range(1));
            ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
            cycle();
        end
    endtask

    initial begin
        int sent, nvalid, ce_after, guard;

        ce_v = 1'b0; clr_v = 1'b0; iv = 1'b0; cj = 1'b0;
        ar = 0; ai = 0; br = 0; bi = 0;
        bus.ce = 1'b0; bus.clr = 1'b0; bus.in_valid = 1'b0; bus.conj = 1'b0;
        bus.A_re = '0; bus.A_im = '0; bus.B_re = '0; bus.B_im = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        resetn = 1'b1;

        // Unity-ish default product and its one-cycle valid pulse.
        send(1'b0, 16384, 0, 16384, 0);
        idle(LAT - 1);
        lit("default", 8192, 0, 1'b0);
        idle(1);
        chk("default_pulse", bus.out_valid, 0);

        // Round-half-up edges.
        send(1'b0, 1, 0, 16384, 0);
        idle(LAT - 1);
        lit("round_pos", 1, 0, 1'b0);
        send(1'b0, -1, 0, 16384, 0);
        idle(LAT - 1);
        lit("round_half", 0, 0, 1'b0);
        send(1'b0, -1, 0, 16385, 0);
        idle(LAT - 1);
        lit("round_neg", -1, 0, 1'b0);

        // Conjugate selection, then alternating conj back to back.
        send(1'b0, 0, 16384, 0, 16384);
        idle(LAT - 1);
        lit("conj0", -8192, 0, 1'b0);
        send(1'b1, 0, 16384, 0, 16384);
        idle(LAT - 1);
        lit("conj1", 8192, 0, 1'b0);
        for (int i = 0; i < 8; i++)
            send(i[0], rnd16(), rnd16(), rnd16(), rnd16());
        idle(LAT);

        // Saturation and the first counter increment.
        clr_v = 1'b1; idle(1); clr_v = 1'b0;
        send(1'b0, -32768, -32768, -32768, -32768);
        idle(LAT - 1);
        lit("sat_im", 0, 32767, 1'b1);
        idle(1);
        chk("sat_cnt_one", bus.sat_cnt, 1);
        send(1'b0, -32768, 0, -32768, 0);
        idle(LAT - 1);
        lit("sat_re", 32767, 0, 1'b1);
        idle(2);

        // Ten samples through a pipeline whose ce toggles randomly.
        sent = 0; nvalid = 0; ce_after = 0; guard = 0;
        while ((sent < 10 || ce_after < LAT) && guard < 2000) begin
            ce_v = 1'($urandom_range(1));
            iv   = (sent < 10);
            cj   = 1'($urandom_range(1));
            ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
            cycle();
            if (ce_v) begin
                if (iv) sent++;
                else ce_after++;
                if (bus.out_valid) nvalid++;
            end
            guard++;
        end
        chk("ce_guard", (guard < 2000), 1);
        chk("ce_valid_count", nvalid, 10);

        // Clear acts with ce low.
        chk("cnt_nonzero", (bus.sat_cnt != 0), 1);
        ce_v = 1'b0; clr_v = 1'b1; iv = 1'b0;
        cycle();
        clr_v = 1'b0;
        chk("clr_ce0", bus.sat_cnt, 0);

        // Counter saturates at 0xFFFF.
        for (int i = 0; i < 65540; i++)
            send(1'b0, -32768, -32768, -32768, -32768);
        idle(LAT);
        chk("cnt_sticky", bus.sat_cnt, 16'hFFFF);

        // Clear beats a simultaneous saturated output.
        send(1'b0, -32768, -32768, -32768, -32768);
        idle(LAT - 1);
        lit("clr_race_out", 0, 32767, 1'b1);
        clr_v = 1'b1; idle(1); clr_v = 1'b0;
        chk("clr_priority", bus.sat_cnt, 0);

        // Asynchronous reset with three samples in flight.
        send(1'b0, 16384, 0, 16384, 0);
        send(1'b1, rnd16(), rnd16(), rnd16(), rnd16());
        send(1'b0, -32768, -32768, -32768, -32768);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_model();
        #1 resetn = 1'b1;
        idle(LAT + 2);
        send(1'b1, rnd16(), rnd16(), rnd16(), rnd16());
        idle(LAT - 1);
        chk("post_reset_valid", bus.out_valid, 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
